// File: rtl/div_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// div_arbiter
//
// Purpose:
//   Shares a single iterative unsigned divider among NUM_REQ low-rate
//   requesters. One pending request is accepted at a time, issued to the
//   divider, and its quotient is returned on a single result stream tagged
//   with the index of the requester that asked for it.
//
// Ports (div_arbiter):
//   clk_i            clock
//   reset_ni         synchronous active-low reset (also resets the divider)
//   s_numerator_i    packed numerators, requester k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   s_denominator_i  packed denominators, same packing
//   s_valid_i        request pending, one bit per requester
//   s_ready_o        one-hot accept, combinational, only while idle
//   m_result_o       quotient of the last completed division (held)
//   m_id_o           requester index that owns m_result_o (held)
//   m_valid_o        single-cycle strobe marking a new result
//   busy_o           high whenever a division is being issued or awaited
//
// Build options:
//   DIV_ARB_FIXED_PRIO_EN  when defined, the lowest pending index always wins
//                          and the round-robin pointer is not built. When
//                          undefined (default), grants rotate round-robin.
//
// Also contains `div`, the iterative restoring divider used by the arbiter.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// div
//
// Purpose:
//   Iterative (one quotient bit per cycle) unsigned restoring divider.
//   A zero numerator or denominator short-circuits to a 0 result one cycle
//   after valid_i. Otherwise the result appears RESULT_WIDTH+1 cycles after
//   valid_i. Quotients that do not fit RESULT_WIDTH bits saturate to all ones.
//   A new valid_i is ignored while a division is running.
//
// Ports:
//   clk_i, reset_ni  clock and synchronous active-low reset
//   numerator_i      dividend, sampled with valid_i
//   denominator_i    divisor, sampled with valid_i
//   valid_i          start strobe
//   result_o         quotient, held until the next completion
//   valid_o          single-cycle completion strobe
// ---------------------------------------------------------------------------
module div #(
  parameter int INPUT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 16,
  parameter bit PIPELINED    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [INPUT_WIDTH-1:0]  numerator_i,
  input  logic [INPUT_WIDTH-1:0]  denominator_i,
  input  logic                    valid_i,
  output logic [RESULT_WIDTH-1:0] result_o,
  output logic                    valid_o
);

  localparam int REM_WIDTH = INPUT_WIDTH + RESULT_WIDTH;
  localparam int CNT_WIDTH = $clog2(RESULT_WIDTH + 1);

  // Only the iterative architecture exists; refuse to elaborate otherwise.
  generate
    if (PIPELINED) begin : g_cfg_check
      $error("div: only the iterative variant (PIPELINED=0) is implemented");
    end
  endgenerate

  logic [REM_WIDTH-1:0]    rem;
  logic [REM_WIDTH-1:0]    dsh;
  logic [RESULT_WIDTH-1:0] quo;
  logic [RESULT_WIDTH-1:0] quo_next;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    running;
  logic                    sat;
  logic                    rem_ge;
  logic                    is_zero;
  logic                    will_sat;

  // One restoring step: compare the partial remainder against the shifted
  // divisor and shift the resulting quotient bit in at the LSB.
  always_comb begin
    rem_ge   = (rem >= dsh);
    quo_next = (quo << 1) | RESULT_WIDTH'(rem_ge);
    is_zero  = (numerator_i == '0) || (denominator_i == '0);
    // The quotient overflows exactly when N >= D * 2^RESULT_WIDTH.
    will_sat = (REM_WIDTH'(numerator_i) >= (REM_WIDTH'(denominator_i) << RESULT_WIDTH));
  end

  // Sequencing: load on valid_i, then RESULT_WIDTH iterations. Saturated
  // divisions still run the full count so latency does not depend on data.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rem      <= '0;
      dsh      <= '0;
      quo      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      sat      <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!running) begin
        if (valid_i) begin
          if (is_zero) begin
            result_o <= '0;
            valid_o  <= 1'b1;
          end else begin
            rem     <= REM_WIDTH'(numerator_i);
            dsh     <= REM_WIDTH'(denominator_i) << (RESULT_WIDTH - 1);
            quo     <= '0;
            cnt     <= CNT_WIDTH'(RESULT_WIDTH);
            sat     <= will_sat;
            running <= 1'b1;
          end
        end
      end else begin
        if (rem_ge) begin
          rem <= rem - dsh;
        end
        dsh <= dsh >> 1;
        quo <= quo_next;
        cnt <= cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) begin
          running  <= 1'b0;
          valid_o  <= 1'b1;
          result_o <= sat ? '1 : quo_next;
        end
      end
    end
  end

endmodule

module div_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int INPUT_WIDTH  = 16,
  parameter  int RESULT_WIDTH = 16,
  localparam int ID_WIDTH     = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] s_numerator_i,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] s_denominator_i,
  input  logic [NUM_REQ-1:0]             s_valid_i,
  output logic [NUM_REQ-1:0]             s_ready_o,
  output logic [RESULT_WIDTH-1:0]        m_result_o,
  output logic [ID_WIDTH-1:0]            m_id_o,
  output logic                           m_valid_o,
  output logic                           busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     grant_id;
  logic                    any_valid;
  logic [INPUT_WIDTH-1:0]  sel_num;
  logic [INPUT_WIDTH-1:0]  sel_den;
  logic [INPUT_WIDTH-1:0]  op_num;
  logic [INPUT_WIDTH-1:0]  op_den;
  logic [ID_WIDTH-1:0]     owner;
  logic                    div_valid_in;
  logic [RESULT_WIDTH-1:0] div_result;
  logic                    div_valid_out;
`ifndef DIV_ARB_FIXED_PRIO_EN
  logic [ID_WIDTH-1:0]     rr_ptr;
`endif

  // Grant selection among the currently pending requesters.
  always_comb begin
    grant_id  = '0;
    any_valid = 1'b0;
`ifdef DIV_ARB_FIXED_PRIO_EN
    // Descending scan: the lowest pending index is assigned last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_valid_i[k]) begin
        grant_id  = ID_WIDTH'(k);
        any_valid = 1'b1;
      end
    end
`else
    // Distance i from the pointer is scanned from far to near, so the
    // nearest pending requester after rr_ptr is assigned last and wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (s_valid_i[k] && (k == ((int'(rr_ptr) + i) % NUM_REQ))) begin
          grant_id  = ID_WIDTH'(k);
          any_valid = 1'b1;
        end
      end
    end
`endif
  end

  // Operand mux for the winner, and the one-hot accept while idle.
  always_comb begin
    sel_num   = '0;
    sel_den   = '0;
    s_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_WIDTH'(k)) begin
        sel_num      = s_numerator_i[k*INPUT_WIDTH +: INPUT_WIDTH];
        sel_den      = s_denominator_i[k*INPUT_WIDTH +: INPUT_WIDTH];
        s_ready_o[k] = reset_ni && (state == IDLE) && any_valid;
      end
    end
  end

  // Control FSM. IDLE accepts and latches a request, ISSUE pulses the
  // divider start for one cycle, WAIT forwards the quotient and returns to
  // IDLE on the same edge so a new accept can happen in the strobe cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state        <= IDLE;
      op_num       <= '0;
      op_den       <= '0;
      owner        <= '0;
      div_valid_in <= 1'b0;
      m_result_o   <= '0;
      m_id_o       <= '0;
      m_valid_o    <= 1'b0;
      busy_o       <= 1'b0;
`ifndef DIV_ARB_FIXED_PRIO_EN
      rr_ptr       <= ID_WIDTH'(NUM_REQ - 1);
`endif
    end else begin
      m_valid_o    <= 1'b0;
      div_valid_in <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_num       <= sel_num;
            op_den       <= sel_den;
            owner        <= grant_id;
            div_valid_in <= 1'b1;
            busy_o       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (div_valid_out) begin
            m_result_o <= div_result;
            m_id_o     <= owner;
            m_valid_o  <= 1'b1;
            busy_o     <= 1'b0;
`ifndef DIV_ARB_FIXED_PRIO_EN
            rr_ptr     <= owner;
`endif
            state      <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  div #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .RESULT_WIDTH (RESULT_WIDTH),
    .PIPELINED    (1'b0)
  ) u_div (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .numerator_i   (op_num),
    .denominator_i (op_den),
    .valid_i       (div_valid_in),
    .result_o      (div_result),
    .valid_o       (div_valid_out)
  );

  // A completion outside WAIT would be silently dropped; it indicates a
  // sequencing bug between the FSM and the divider.
  a_div_valid_only_in_wait: assert property (
    @(posedge clk_i) disable iff (!reset_ni) div_valid_out |-> (state == WAIT)
  );

endmodule

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps
module tb_div_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IW      = 16;
  localparam int RW      = 16;
  localparam int NREQ8   = 2;
  localparam int RW8     = 8;

  logic clk_i = 1'b0;
  logic reset_ni;

  // Default-width instance
  logic [NUM_REQ*IW-1:0] s_numerator;
  logic [NUM_REQ*IW-1:0] s_denominator;
  logic [NUM_REQ-1:0]    s_valid;
  logic [NUM_REQ-1:0]    s_ready;
  logic [RW-1:0]         m_result;
  logic [1:0]            m_id;
  logic                  m_valid;
  logic                  busy;

  // Narrow-quotient instance for saturation boundaries
  logic [NREQ8*IW-1:0]   n8_num;
  logic [NREQ8*IW-1:0]   n8_den;
  logic [NREQ8-1:0]      n8_valid;
  logic [NREQ8-1:0]      n8_ready;
  logic [RW8-1:0]        n8_result;
  logic                  n8_id;
  logic                  n8_mvalid;
  logic                  n8_busy;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct {
    bit          narrow;
    int          id;
    logic [15:0] num;
    logic [15:0] den;
    logic [15:0] exp_q;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  always #5 clk_i = ~clk_i;

  div_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .INPUT_WIDTH  (IW),
    .RESULT_WIDTH (RW)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .s_numerator_i   (s_numerator),
    .s_denominator_i (s_denominator),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready),
    .m_result_o      (m_result),
    .m_id_o          (m_id),
    .m_valid_o       (m_valid),
    .busy_o          (busy)
  );

  div_arbiter #(
    .NUM_REQ      (NREQ8),
    .INPUT_WIDTH  (IW),
    .RESULT_WIDTH (RW8)
  ) dut8 (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .s_numerator_i   (n8_num),
    .s_denominator_i (n8_den),
    .s_valid_i       (n8_valid),
    .s_ready_o       (n8_ready),
    .m_result_o      (n8_result),
    .m_id_o          (n8_id),
    .m_valid_o       (n8_mvalid),
    .busy_o          (n8_busy)
  );

  // Global time limit so the bench always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_req(input bit narrow, input int id, input logic [15:0] num,
                         input logic [15:0] den, input logic v);
    if (narrow) begin
      for (int k = 0; k < NREQ8; k++) begin
        if (k == id) begin
          n8_num[k*IW +: IW] = num;
          n8_den[k*IW +: IW] = den;
          n8_valid[k]        = v;
        end
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == id) begin
          s_numerator[k*IW +: IW]   = num;
          s_denominator[k*IW +: IW] = den;
          s_valid[k]                = v;
        end
      end
    end
  endtask

  function automatic logic [31:0] ready_vec(input bit narrow);
    return narrow ? 32'(n8_ready) : 32'(s_ready);
  endfunction

  function automatic logic out_valid(input bit narrow);
    return narrow ? n8_mvalid : m_valid;
  endfunction

  function automatic logic out_busy(input bit narrow);
    return narrow ? n8_busy : busy;
  endfunction

  function automatic logic [31:0] out_result(input bit narrow);
    return narrow ? 32'(n8_result) : 32'(m_result);
  endfunction

  function automatic logic [31:0] out_id(input bit narrow);
    return narrow ? 32'(n8_id) : 32'(m_id);
  endfunction

  // One isolated request: wait for accept, measure latency to the strobe,
  // then check result, tag, pulse width and hold behaviour.
  task automatic applyStimulus(input vec_t v, input int idx);
    bit got_ready;
    bit got_valid;
    int lat;
    logic [31:0] held;
    got_ready = 1'b0;
    got_valid = 1'b0;
    lat       = 0;
    @(negedge clk_i);
    set_req(v.narrow, v.id, v.num, v.den, 1'b1);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready_vec(v.narrow) != 0) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checkOutput($sformatf("vec%0d ready one-hot", idx), ready_vec(v.narrow), 32'(1) << v.id);
    if (!got_ready) begin
      set_req(v.narrow, v.id, 16'd0, 16'd0, 1'b0);
      return;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        set_req(v.narrow, v.id, 16'd0, 16'd0, 1'b0);
        checkOutput($sformatf("vec%0d busy after accept", idx), 32'(out_busy(v.narrow)), 1);
      end
      if (out_valid(v.narrow)) begin
        lat       = c;
        got_valid = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("vec%0d latency", idx), lat, v.exp_lat);
    checkOutput($sformatf("vec%0d result", idx), out_result(v.narrow), 32'(v.exp_q));
    checkOutput($sformatf("vec%0d id", idx), out_id(v.narrow), v.id);
    checkOutput($sformatf("vec%0d busy at strobe", idx), 32'(out_busy(v.narrow)), 0);
    held = out_result(v.narrow);
    @(negedge clk_i);
    checkOutput($sformatf("vec%0d strobe single cycle", idx), 32'(out_valid(v.narrow)), 0);
    if (got_valid) begin
      checkOutput($sformatf("vec%0d result held", idx), out_result(v.narrow), 32'(v.exp_q));
    end else begin
      checkOutput($sformatf("vec%0d result held", idx), out_result(v.narrow), held);
    end
  endtask

  initial begin
    int acc_id [4];
    int acc_t  [4];
    int str_id [4];
    int str_res[4];
    int str_t  [4];
    int rr_ids [4];
    int na;
    int ns;
    int overlap;
    int strobes;
    logic [NUM_REQ-1:0] clear_mask;

    reset_ni      = 1'b0;
    s_numerator   = '0;
    s_denominator = '0;
    s_valid       = '0;
    n8_num        = '0;
    n8_den        = '0;
    n8_valid      = '0;

    repeat (3) @(negedge clk_i);
    checkOutput("reset m_valid", 32'(m_valid), 0);
    checkOutput("reset m_result", 32'(m_result), 0);
    checkOutput("reset m_id", 32'(m_id), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset s_ready", 32'(s_ready), 0);
    checkOutput("reset narrow outputs", {n8_mvalid, n8_busy, n8_id, 21'd0, n8_result}, 0);
    reset_ni = 1'b1;

    // {narrow, id, num, den, expected quotient, expected latency}
    vecs[0]  = '{1'b0, 1, 16'd100,   16'd7,     16'd14,    19};
    vecs[1]  = '{1'b0, 2, 16'd500,   16'd0,     16'd0,     3};
    vecs[2]  = '{1'b0, 0, 16'd0,     16'd9,     16'd0,     3};
    vecs[3]  = '{1'b0, 3, 16'd65535, 16'd1,     16'd65535, 19};
    vecs[4]  = '{1'b0, 0, 16'd65535, 16'd65535, 16'd1,     19};
    vecs[5]  = '{1'b0, 2, 16'd1000,  16'd3,     16'd333,   19};
    vecs[6]  = '{1'b0, 1, 16'd5,     16'd10,    16'd0,     19};
    vecs[7]  = '{1'b1, 0, 16'd1000,  16'd1,     16'd255,   11};
    vecs[8]  = '{1'b1, 1, 16'd65535, 16'd65535, 16'd1,     11};
    vecs[9]  = '{1'b1, 0, 16'd255,   16'd1,     16'd255,   11};
    vecs[10] = '{1'b1, 1, 16'd256,   16'd1,     16'd255,   11};
    vecs[11] = '{1'b1, 0, 16'd510,   16'd2,     16'd255,   11};
    vecs[12] = '{1'b1, 1, 16'd100,   16'd3,     16'd33,    11};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset five cycles into a division: job dropped, outputs cleared.
    @(negedge clk_i);
    set_req(1'b0, 2, 16'd100, 16'd7, 1'b1);
    #1;
    checkOutput("rst-wait ready", 32'(s_ready), 32'b0100);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      if (c == 1) set_req(1'b0, 2, 16'd0, 16'd0, 1'b0);
    end
    reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    checkOutput("rst-wait m_valid", 32'(m_valid), 0);
    checkOutput("rst-wait m_result", 32'(m_result), 0);
    checkOutput("rst-wait m_id", 32'(m_id), 0);
    checkOutput("rst-wait busy", 32'(busy), 0);
    strobes = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_i);
      if (m_valid) strobes++;
    end
    checkOutput("rst-wait dropped job strobes", strobes, 0);
    applyStimulus('{1'b0, 3, 16'd300, 16'd7, 16'd42, 19}, 100);

    // All four requesters at once, each held until accepted.
    for (int i = 0; i < 4; i++) begin
      acc_id[i] = -1; acc_t[i] = -1; str_id[i] = -1; str_res[i] = -1; str_t[i] = -1;
    end
    na = 0; ns = 0; overlap = 0; clear_mask = '0;
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) set_req(1'b0, k, 16'd60, 16'(k + 1), 1'b1);
    for (int cyc = 0; cyc < 150 && ns < 4; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      s_valid = s_valid & ~clear_mask;
      #1;
      if (m_valid && ns < 4) begin
        str_id[ns]  = int'(m_id);
        str_res[ns] = int'(m_result);
        str_t[ns]   = cyc;
        ns++;
      end
      if ($countones(s_ready) > 1) overlap++;
      if (s_ready != 0 && na < 4) begin
        for (int k = 0; k < 4; k++) if (s_ready[k]) acc_id[na] = k;
        acc_t[na] = cyc;
        na++;
      end
      clear_mask = s_ready;
    end
    s_valid = '0;
    checkOutput("all4 grant overlap", overlap, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("all4 accept order %0d", i), acc_id[i], i);
      checkOutput($sformatf("all4 result id %0d", i), str_id[i], i);
      checkOutput($sformatf("all4 result %0d", i), str_res[i], 60 / (i + 1));
      checkOutput($sformatf("all4 latency %0d", i), str_t[i] - acc_t[i], 19);
      if (i > 0) checkOutput($sformatf("all4 spacing %0d", i), acc_t[i] - acc_t[i-1], 19);
    end

    // Requesters 0 and 3 keep requesting.
    for (int i = 0; i < 4; i++) rr_ids[i] = -1;
    na = 0;
    @(negedge clk_i);
    set_req(1'b0, 0, 16'd50, 16'd5, 1'b1);
    set_req(1'b0, 3, 16'd90, 16'd9, 1'b1);
    for (int cyc = 0; cyc < 150 && na < 4; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      #1;
      if (s_ready != 0) begin
        for (int k = 0; k < 4; k++) if (s_ready[k]) rr_ids[na] = k;
        na++;
      end
    end
    @(negedge clk_i);
    s_valid = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef DIV_ARB_FIXED_PRIO_EN
      checkOutput($sformatf("fixed-prio grant %0d", i), rr_ids[i], 0);
`else
      checkOutput($sformatf("rr grant %0d", i), rr_ids[i], (i % 2 == 0) ? 0 : 3);
`endif
    end
    for (int c = 0; c < 40 && busy; c++) @(negedge clk_i);
    checkOutput("rr drain busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative (non-pipelined) `div` instance, with PIPELINED=0, among NUM_REQ requesters.
- Arbitrates between pending requests, issues one division at a time, and waits for completion.
- Returns each quotient on a single result stream tagged with the requester index.
- Used where several low-rate control paths (e.g. CFO/SNR normalisation) each need an occasional unsigned division and a pipelined divider per path is too costly.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- INPUT_WIDTH, 16, numerator/denominator width, passed to div.
- RESULT_WIDTH, 16, quotient width, passed to div.
- ID_WIDTH (localparam), max(1, $clog2(NUM_REQ)), width of the requester tag.

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  synchronous active-low reset, also drives the div instance
- s_numerator_i  input  NUM_REQ*INPUT_WIDTH  numerators, requester k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- s_denominator_i  input  NUM_REQ*INPUT_WIDTH  denominators, same packing
- s_valid_i  input  NUM_REQ  request pending per requester
- s_ready_o  output  NUM_REQ  one-hot accept, combinational
- m_result_o  output  RESULT_WIDTH  quotient, registered
- m_id_o  output  ID_WIDTH  index of the requester that owns m_result_o
- m_valid_o  output  1  one-cycle result strobe, no backpressure
- busy_o  output  1  high whenever the FSM is not IDLE

Behaviour:
- Clocking: one clock; reset is synchronous and active-low (reset_ni sampled on rising clk_i).
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE:
    - If any s_valid_i bit is set, select grant g, assert s_ready_o[g] this cycle only.
    - Latch operands and g; next state ISSUE.
    - If no bit is set, stay in IDLE.
  - ISSUE: drive div valid_i=1 for exactly one cycle with the latched operands; next state WAIT.
  - WAIT:
    - Hold div valid_i=0.
    - On div valid_o=1: register result into m_result_o, m_id_o <= g, m_valid_o <= 1, update RR pointer <= g, next state IDLE.
- s_ready_o is 0 outside IDLE. At most one bit is set at any time.
- Requester protocol:
  - Once s_valid_i[k] rises, it stays high with stable operands until s_ready_o[k].
  - Deasserting s_valid_i[k] before acceptance withdraws the request; this is legal.
- Arbitration: round-robin. Search begins at pointer+1 (mod NUM_REQ); the first set s_valid_i bit wins.
- Latency, counting the accept cycle (s_valid_i & s_ready_o) as T:
  - Normal case: m_valid_o is high in cycle T+RESULT_WIDTH+3.
  - If numerator==0 or denominator==0: div short-circuits and m_valid_o is high in T+3 with m_result_o=0.
- m_valid_o is a single-cycle pulse. m_result_o and m_id_o hold their value until the next strobe.
- Back-to-back operation:
  - The FSM re-enters IDLE on the same edge that raises m_valid_o.
  - A new accept may occur in the strobe cycle.
  - Throughput is one division per RESULT_WIDTH+3 cycles.
- Arithmetic: unsigned only.
  - Quotients >= 2^RESULT_WIDTH saturate to all ones (inherent to div).
  - Remainder is discarded.
- Reset mid-operation: the in-flight division is dropped, no m_valid_o is produced, and the pending requester is not re-served automatically.
- Divider handshake: div valid_o is ignored outside WAIT. This cannot occur with correct sequencing; an assertion flags it in simulation.

Optional Feature:
DIV_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest set s_valid_i index always wins and the RR pointer is unused. Starvation of higher indices is accepted.
- Undefined (default): round-robin as described above.
- All other timing is identical in both cases.

Test Plan:
- Single request (defaults), requester 1, 100/7, accepted in cycle T -> m_valid_o in T+19, m_result_o=14, m_id_o=1, busy_o high T+1..T+18.
- Zero operand, requester 2, 500/0; then requester 0, 0/9 -> each m_result_o=0, m_valid_o 3 cycles after its accept.
- All four requesters valid simultaneously, distinct operands (e.g. 60/k+1), held until ready -> accept order 0,1,2,3, results 60,30,20,15 with matching ids. Spacing is 19 cycles and no grant overlaps.
- Round-robin fairness: requesters 0 and 3 permanently re-request -> grants alternate 0,3,0,3.
  - With DIV_ARB_FIXED_PRIO_EN defined: grants 0,0,0 and 3 is starved.
- Reset mid-WAIT: reset_ni low for 1 cycle, 5 cycles after an accept -> all outputs 0 next cycle, no m_valid_o for the dropped job. The next request completes normally with the correct result.
- Saturation/boundary: RESULT_WIDTH=8, INPUT_WIDTH=16, 1000/1 -> m_result_o=255; 65535/65535 -> 1.
